// File: rtl/mem_test_engine_if.sv
// mem_test_engine_if: CPU-side memory request/ack bus.
// The engine drives the master side; the memory subsystem is the slave.
interface mem_test_engine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] mem_write_data;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_write_data,
        input  mem_ack,
        input  mem_read_data
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_write_data,
        output mem_ack,
        output mem_read_data
    );
endinterface

// File: rtl/mem_test_engine.sv
// mem_test_engine: walks a BASE..BASE+DEPTH-1 window, writing a seeded
// address pattern and reading it back, for PASSES passes with the pattern
// inverted on odd passes. Reports pass/fail, saturating error count and
// the first failing address.
// Optional feature: define MEMTEST_TIMEOUT_EN to enable the ack watchdog
// (TIMEOUT cycles without ack in WRITE/READ ends the test in TIMEOUT).
module mem_test_engine #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter logic [ADDR_W-1:0] BASE    = '0,
    parameter int                DEPTH   = 256,
    parameter logic [31:0]       SEED    = 32'hA5A5_A5A5,
    parameter int                PASSES  = 2,
    parameter int                TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            err_count,
    output logic [ADDR_W-1:0]      fail_addr,
    output logic [2:0]             state,
    mem_test_engine_if.master      mem
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE_WRITE = 3'd1,
        S_WRITE     = 3'd2,
        S_PRE_READ  = 3'd3,
        S_READ      = 3'd4,
        S_DONE      = 3'd5,
        S_TIMEOUT   = 3'd6
    } state_e;

    localparam int                PW        = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE + ADDR_W'(DEPTH - 1);
    localparam logic [PW-1:0]     LAST_PASS = PW'(PASSES - 1);

    // Expected word at address a; odd passes use the inverted polarity so
    // every cell is exercised with both values of each bit.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic odd);
        logic [DATA_W-1:0] v;
        v = DATA_W'(a) ^ DATA_W'(SEED);
        return odd ? ~v : v;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [PW-1:0]     pidx_q, pidx_d;
    logic [15:0]       err_q, err_d;
    logic [ADDR_W-1:0] fail_q, fail_d;
    logic              pass_q, pass_d;
    logic              rd_mismatch;

`ifdef MEMTEST_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt_q, tcnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign rd_mismatch = (mem.mem_read_data != pattern(addr_q, pidx_q[0]));

    // Next-state and next-output computation for the whole walk sequence.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        pidx_d      = pidx_q;
        err_d       = err_q;
        fail_d      = fail_q;
        pass_d      = pass_q;
`ifdef MEMTEST_TIMEOUT_EN
        tcnt_d      = tcnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) begin
                    state_d = S_PRE_WRITE;
                    addr_d  = BASE;
                    pidx_d  = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_PRE_WRITE: begin
                wdata_d     = pattern(addr_q, pidx_q[0]);
                mem_write_d = 1'b1;
                state_d     = S_WRITE;
`ifdef MEMTEST_TIMEOUT_EN
                tcnt_d      = '0;
`endif
            end
            S_WRITE: begin
                mem_write_d = 1'b1;
                if (mem.mem_ack) begin
                    mem_write_d = 1'b0;
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = BASE;
                        state_d = S_PRE_READ;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_PRE_WRITE;
                    end
                end
`ifdef MEMTEST_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    mem_write_d = 1'b0;
                    fail_d      = addr_q;
                    pass_d      = 1'b0;
                    state_d     = S_TIMEOUT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            S_PRE_READ: begin
                mem_read_d = 1'b1;
                state_d    = S_READ;
`ifdef MEMTEST_TIMEOUT_EN
                tcnt_d     = '0;
`endif
            end
            S_READ: begin
                mem_read_d = 1'b1;
                if (mem.mem_ack) begin
                    mem_read_d = 1'b0;
                    if (rd_mismatch) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0)    fail_d = addr_q;
                    end
                    if (addr_q == LAST_ADDR) begin
                        addr_d = BASE;
                        if (pidx_q == LAST_PASS) begin
                            pass_d  = (err_d == 16'd0);
                            state_d = S_DONE;
                        end else begin
                            pidx_d  = pidx_q + PW'(1);
                            state_d = S_PRE_WRITE;
                        end
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_PRE_READ;
                    end
                end
`ifdef MEMTEST_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    mem_read_d = 1'b0;
                    fail_d     = addr_q;
                    pass_d     = 1'b0;
                    state_d    = S_TIMEOUT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything, dropping any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            pidx_q      <= '0;
            err_q       <= '0;
            fail_q      <= '0;
            pass_q      <= 1'b0;
`ifdef MEMTEST_TIMEOUT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            pidx_q      <= pidx_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            pass_q      <= pass_d;
`ifdef MEMTEST_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    assign busy               = !(state_q inside {S_IDLE, S_DONE, S_TIMEOUT});
    assign done               = (state_q == S_DONE) || (state_q == S_TIMEOUT);
    assign pass               = pass_q;
    assign err_count          = err_q;
    assign fail_addr          = fail_q;
    assign state              = state_q;
    assign mem.mem_read       = mem_read_q;
    assign mem.mem_write      = mem_write_q;
    assign mem.mem_addr       = addr_q;
    assign mem.mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_test_engine.sv
// tb_mem_test_engine: scoreboard bench for mem_test_engine with a RAM
// responder supporting zero/random ack delay, a stuck-at-0 bit, withheld
// acks and spurious acks.
module tb_mem_test_engine;
    localparam int          AW     = 8;
    localparam int          DW     = 16;
    localparam int          DEPTH  = 4;
    localparam int          PASSES = 2;
    localparam logic [7:0]  BASE_A = 8'h10;
    localparam logic [15:0] SEED_V = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [7:0]  fail_addr;
    logic [2:0]  state;

    mem_test_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_test_engine #(
        .ADDR_W(AW), .DATA_W(DW), .BASE(BASE_A), .DEPTH(DEPTH),
        .SEED(32'(SEED_V)), .PASSES(PASSES), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_addr(fail_addr),
        .state(state), .mem(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] data;
    } txn_t;

    txn_t        obs_q[$];
    txn_t        exp_q[$];
    logic [15:0] ram [0:255];
    int          checks = 0;
    int          errors = 0;
    bit          rand_wait = 0;
    bit          ack_en = 1;
    bit          stuck_en = 0;
    bit          spur_en = 0;
    int          wait_total = 0;
    int          spur_count = 0;
    int          proto_errs = 0;

    function automatic logic [15:0] model_pat(input logic [7:0] a, input int p);
        logic [15:0] v;
        v = {8'h00, a} ^ SEED_V;
        return (p % 2 == 1) ? ~v : v;
    endfunction

    // RAM responder and protocol monitor; decides ack on the falling edge.
    initial begin : responder
        int          wait_left;
        logic        req, ack, prev_req, prev_txn_ack, prev_we;
        logic [7:0]  prev_addr;
        logic [15:0] prev_wdata;
        txn_t        t;
        wait_left = -1;
        prev_req = 0; prev_txn_ack = 0; prev_we = 0; prev_addr = 0; prev_wdata = 0;
        bus.mem_ack = 1'b0;
        bus.mem_read_data = '0;
        forever begin
            @(negedge clk);
            req = bus.mem_read | bus.mem_write;
            ack = 1'b0;
            if (bus.mem_read && bus.mem_write) proto_errs++;
            if (prev_txn_ack && req) proto_errs++;
            if (req && prev_req && !prev_txn_ack &&
                (bus.mem_write !== prev_we || bus.mem_addr !== prev_addr ||
                 (bus.mem_write && bus.mem_write_data !== prev_wdata)))
                proto_errs++;
            prev_txn_ack = 1'b0;
            if (req && ack_en) begin
                if (wait_left < 0) wait_left = rand_wait ? int'($urandom_range(0, 3)) : 0;
                if (wait_left == 0) begin
                    ack = 1'b1;
                    wait_left = -1;
                    prev_txn_ack = 1'b1;
                    t.we = bus.mem_write;
                    t.addr = bus.mem_addr;
                    if (bus.mem_write) begin
                        t.data = bus.mem_write_data;
                        ram[bus.mem_addr] = (stuck_en && bus.mem_addr == 8'h12) ?
                                            (bus.mem_write_data & 16'hFFFE) : bus.mem_write_data;
                    end else begin
                        t.data = ram[bus.mem_addr];
                        bus.mem_read_data = ram[bus.mem_addr];
                    end
                    obs_q.push_back(t);
                end else begin
                    wait_left--;
                    wait_total++;
                end
            end else if (!req) begin
                wait_left = -1;
                if (spur_en && state == 3'd1) begin
                    ack = 1'b1;
                    spur_count++;
                end
            end
            prev_req = req;
            prev_we = bus.mem_write;
            prev_addr = bus.mem_addr;
            prev_wdata = bus.mem_write_data;
            bus.mem_ack = ack;
        end
    end

    // Pushes the expected write/read stream and returns the expected result.
    task automatic push_expected(output int e_err, output logic [7:0] e_fail);
        logic [7:0]  a;
        logic [15:0] w, stored;
        e_err = 0;
        e_fail = 8'h00;
        for (int p = 0; p < PASSES; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = BASE_A + 8'(i);
                exp_q.push_back({1'b1, a, model_pat(a, p)});
            end
            for (int i = 0; i < DEPTH; i++) begin
                a = BASE_A + 8'(i);
                w = model_pat(a, p);
                stored = (stuck_en && a == 8'h12) ? (w & 16'hFFFE) : w;
                exp_q.push_back({1'b0, a, w});
                if (stored !== w) begin
                    if (e_err == 0) e_fail = a;
                    e_err++;
                end
            end
        end
    endtask

    // Starts the engine and waits for done; lat counts edges from the start edge.
    task automatic run_engine(input bit poke, output int lat, output bit tmo);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        tmo = 1'b0;
        while (!done) begin
            if (lat > 3000) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
            start = poke && busy && (lat % 3 == 1);
            @(posedge clk);
            #1 start = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d expected 0", state); end
        checks++; if ({busy, done, pass, bus.mem_read, bus.mem_write} !== 5'b0) begin
            errors++; $display("FAIL rst_flags got %b expected 00000", {busy, done, pass, bus.mem_read, bus.mem_write}); end
        checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL rst_err got %h expected 0000", err_count); end
        checks++; if (fail_addr !== 8'h0) begin errors++; $display("FAIL rst_fail got %h expected 00", fail_addr); end
        checks++; if (bus.mem_addr !== 8'h0) begin errors++; $display("FAIL rst_addr got %h expected 00", bus.mem_addr); end
        checks++; if (bus.mem_write_data !== 16'h0) begin errors++; $display("FAIL rst_wdata got %h expected 0000", bus.mem_write_data); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_wait;
        int lat, e_err; bit tmo; logic [7:0] e_fail; txn_t e, o;
        obs_q.delete(); exp_q.delete(); proto_errs = 0; wait_total = 0;
        push_expected(e_err, e_fail);
        run_engine(1'b0, lat, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL zw_timeout got no done expected done"); end
        checks++; if (lat !== 1 + 4 * DEPTH * PASSES) begin errors++; $display("FAIL zw_latency got %0d expected %0d", lat, 1 + 4 * DEPTH * PASSES); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zw_pass got %b expected 1", pass); end
        checks++; if (err_count !== 16'(e_err)) begin errors++; $display("FAIL zw_err got %0d expected %0d", err_count, e_err); end
        checks++; if (fail_addr !== e_fail) begin errors++; $display("FAIL zw_fail got %h expected %h", fail_addr, e_fail); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL zw_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                errors++;
                $display("FAIL zw_txn got we=%b addr=%h data=%h expected we=%b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
        end
        checks++; if (proto_errs !== 0) begin errors++; $display("FAIL zw_protocol got %0d violations expected 0", proto_errs); end
    endtask

    task automatic test_stuck_bit;
        int lat, e_err; bit tmo; logic [7:0] e_fail;
        obs_q.delete(); exp_q.delete();
        stuck_en = 1'b1;
        // A single stuck-at-0 bit only disagrees with the polarity that writes a 1 there.
        push_expected(e_err, e_fail);
        run_engine(1'b0, lat, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL stuck_timeout got no done expected done"); end
        checks++; if (err_count !== 16'(e_err)) begin errors++; $display("FAIL stuck_err got %0d expected %0d", err_count, e_err); end
        checks++; if (fail_addr !== e_fail) begin errors++; $display("FAIL stuck_fail got %h expected %h", fail_addr, e_fail); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass got %b expected 0", pass); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if ({done, pass, err_count, fail_addr} !== {1'b1, 1'b0, 16'(e_err), e_fail}) begin
            errors++; $display("FAIL stuck_hold got done=%b pass=%b err=%0d fail=%h expected 1 0 %0d %h", done, pass, err_count, fail_addr, e_err, e_fail); end
        stuck_en = 1'b0;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_delay;
        int lat, e_err; bit tmo; logic [7:0] e_fail; txn_t e, o;
        obs_q.delete(); exp_q.delete(); proto_errs = 0; wait_total = 0;
        rand_wait = 1'b1;
        push_expected(e_err, e_fail);
        run_engine(1'b0, lat, tmo);
        rand_wait = 1'b0;
        checks++; if (tmo) begin errors++; $display("FAIL rnd_timeout got no done expected done"); end
        checks++; if (lat !== 1 + 4 * DEPTH * PASSES + wait_total) begin
            errors++; $display("FAIL rnd_latency got %0d expected %0d", lat, 1 + 4 * DEPTH * PASSES + wait_total); end
        checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin errors++; $display("FAIL rnd_result got pass=%b err=%0d expected pass=1 err=0", pass, err_count); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                errors++;
                $display("FAIL rnd_txn got we=%b addr=%h data=%h expected we=%b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
        end
        checks++; if (proto_errs !== 0) begin errors++; $display("FAIL rnd_protocol got %0d violations expected 0", proto_errs); end
    endtask

    task automatic test_reset_mid_read;
        int lat, n; bit tmo;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!(state == 3'd4 && bus.mem_addr == 8'h11) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL mid_reach got no READ@11 expected READ@11"); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_state got %0d expected 0", state); end
        checks++; if ({busy, done, pass, bus.mem_read, bus.mem_write} !== 5'b0) begin
            errors++; $display("FAIL mid_flags got %b expected 00000", {busy, done, pass, bus.mem_read, bus.mem_write}); end
        checks++; if ({err_count, fail_addr, bus.mem_addr, bus.mem_write_data} !== '0) begin
            errors++; $display("FAIL mid_values got err=%h fail=%h addr=%h wdata=%h expected all 0", err_count, fail_addr, bus.mem_addr, bus.mem_write_data); end
        @(negedge clk);
        reset = 1'b0;
        obs_q.delete(); exp_q.delete();
        run_engine(1'b0, lat, tmo);
        checks++; if (tmo || lat !== 33) begin errors++; $display("FAIL mid_rerun_latency got %0d expected 33", lat); end
        checks++; if (pass !== 1'b1 || err_count !== 16'h0) begin errors++; $display("FAIL mid_rerun_result got pass=%b err=%0d expected pass=1 err=0", pass, err_count); end
        obs_q.delete();
    endtask

    task automatic test_start_busy_spurious;
        int lat; bit tmo;
        obs_q.delete(); exp_q.delete(); proto_errs = 0; spur_count = 0;
        spur_en = 1'b1;
        run_engine(1'b1, lat, tmo);
        spur_en = 1'b0;
        checks++; if (tmo || lat !== 33) begin errors++; $display("FAIL spur_latency got %0d expected 33", lat); end
        checks++; if (pass !== 1'b1 || err_count !== 16'h0 || fail_addr !== 8'h00) begin
            errors++; $display("FAIL spur_result got pass=%b err=%0d fail=%h expected 1 0 00", pass, err_count, fail_addr); end
        checks++; if (obs_q.size() !== 2 * DEPTH * PASSES) begin errors++; $display("FAIL spur_count got %0d expected %0d", obs_q.size(), 2 * DEPTH * PASSES); end
        checks++; if (spur_count == 0) begin errors++; $display("FAIL spur_injected got 0 expected >0"); end
        checks++; if (proto_errs !== 0) begin errors++; $display("FAIL spur_protocol got %0d violations expected 0", proto_errs); end
        obs_q.delete();
    endtask

    task automatic test_ack_timeout;
        int n;
        ack_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
`ifdef MEMTEST_TIMEOUT_EN
        while (state != 3'd6 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        checks++; if (n !== 17) begin errors++; $display("FAIL tmo_latency got %0d expected 17", n); end
        checks++; if ({done, pass, busy, bus.mem_write} !== 4'b1000) begin
            errors++; $display("FAIL tmo_flags got %b expected 1000", {done, pass, busy, bus.mem_write}); end
        checks++; if (fail_addr !== 8'h10) begin errors++; $display("FAIL tmo_fail got %h expected 10", fail_addr); end
`else
        repeat (40) begin
            @(posedge clk);
            #1 n++;
        end
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL stall_state got %0d expected 2", state); end
        checks++; if ({done, busy, bus.mem_write} !== 3'b011) begin
            errors++; $display("FAIL stall_flags got %b expected 011", {done, busy, bus.mem_write}); end
        checks++; if (bus.mem_addr !== 8'h10) begin errors++; $display("FAIL stall_addr got %h expected 10", bus.mem_addr); end
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ack_en = 1'b1;
        obs_q.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_stuck_bit();
        test_random_delay();
        test_reset_mid_read();
        test_start_busy_spurious();
        test_ack_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
